// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the framebuffer arbiter slice.
package vga_fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;
    localparam int FB_DEPTH  = 76800;
    localparam int READ_LAT  = 3;

    typedef logic [FB_DATA_W-1:0] pixel_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Scanout, writer, clear and RAM-side signals of the framebuffer arbiter.
interface vga_fb_arbiter_if
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) ();

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic              clear_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clear_start, clear_color, mem_rdata,
        input  rd_valid, rd_data, wr_ready, clear_busy, clear_done, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clear_start, clear_color, mem_rdata,
        output rd_valid, rd_data, wr_ready, clear_busy, clear_done, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vga_fb_wr_fifo.sv
// Two-entry synchronous FIFO buffering writer requests; exposes next-cycle fullness.
module vga_fb_wr_fifo #(
    parameter int W = 29
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full_next
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         push_ok;
    logic         pop_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

    assign head      = mem[rd_ptr];
    assign empty     = (count == 2'd0);
    assign full_next = (count_next == 2'd2);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: fixed-latency scanout reads, buffered writer, clear engine.
// Optional stall/drop counters are built when VGA_FB_ARB_STATS_EN is defined.
//
// state    | meaning
// ST_IDLE  | reads first, then buffered writes; a pending clear waits for the FIFO to drain
// ST_CLEAR | clear engine fills every slot not taken by a read, writer is held off
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
`ifdef VGA_FB_ARB_STATS_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       drop_cnt,
`endif
    vga_fb_arbiter_if.slave   bus
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam int                ENT_W   = ADDR_W + DATA_W;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_addr, clr_addr_next;
    logic [DATA_W-1:0] clr_color, clr_color_next;
    logic              clr_pend, clr_pend_next;
    logic              done_next;
    logic              mem_en_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              push, pop;
    logic [ENT_W-1:0]  head;
    logic              fifo_empty, fifo_full_next;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              head_in_range, rd_in_range;
    logic              wr_ready_q;
    logic              rd_p1, rd_p2, rd_oor1, rd_oor2;

    assign head_addr      = head[ENT_W-1:DATA_W];
    assign head_data      = head[DATA_W-1:0];
    assign head_in_range  = (head_addr < DEPTH_A);
    assign rd_in_range    = (bus.rd_addr < DEPTH_A);
    assign push           = bus.wr_valid && wr_ready_q;
    assign bus.wr_ready   = wr_ready_q;
    assign bus.clear_busy = (state == ST_CLEAR);

    vga_fb_wr_fifo #(.W(ENT_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.wr_addr, bus.wr_data}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full_next (fifo_full_next)
    );

    always_comb begin
        state_next     = state;
        clr_addr_next  = clr_addr;
        clr_color_next = clr_color;
        clr_pend_next  = clr_pend;
        done_next      = 1'b0;
        pop            = 1'b0;
        mem_en_n       = 1'b0;
        mem_we_n       = 1'b0;
        mem_addr_n     = '0;
        mem_wdata_n    = '0;

        // A read owns its slot even when out of range, so its latency never moves.
        if (bus.rd_req) begin
            mem_en_n   = rd_in_range;
            mem_addr_n = rd_in_range ? bus.rd_addr : '0;
        end

        case (state)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    clr_pend_next  = 1'b1;
                    clr_color_next = bus.clear_color;
                end
                if (!bus.rd_req && !fifo_empty) begin
                    pop         = 1'b1;
                    mem_en_n    = head_in_range;
                    mem_we_n    = head_in_range;
                    mem_addr_n  = head_in_range ? head_addr : '0;
                    mem_wdata_n = head_in_range ? head_data : '0;
                end
                if ((bus.clear_start || clr_pend) && fifo_empty) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                    clr_pend_next = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (!bus.rd_req) begin
                    mem_en_n    = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = clr_addr;
                    mem_wdata_n = clr_color;
                    if (clr_addr == LAST_A) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        clr_addr_next = clr_addr + ADDR_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            clr_addr       <= '0;
            clr_color      <= '0;
            clr_pend       <= 1'b0;
            wr_ready_q     <= 1'b1;
            bus.clear_done <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            rd_p1          <= 1'b0;
            rd_p2          <= 1'b0;
            rd_oor1        <= 1'b0;
            rd_oor2        <= 1'b0;
            bus.rd_valid   <= 1'b0;
            bus.rd_data    <= '0;
        end else begin
            state          <= state_next;
            clr_addr       <= clr_addr_next;
            clr_color      <= clr_color_next;
            clr_pend       <= clr_pend_next;
            wr_ready_q     <= !fifo_full_next && (state_next == ST_IDLE);
            bus.clear_done <= done_next;
            bus.mem_en     <= mem_en_n;
            bus.mem_we     <= mem_we_n;
            bus.mem_addr   <= mem_addr_n;
            bus.mem_wdata  <= mem_wdata_n;
            rd_p1          <= bus.rd_req;
            rd_oor1        <= bus.rd_req && !rd_in_range;
            rd_p2          <= rd_p1;
            rd_oor2        <= rd_oor1;
            bus.rd_valid   <= rd_p2;
            bus.rd_data    <= (rd_p2 && !rd_oor2) ? bus.mem_rdata : '0;
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (bus.wr_valid && !wr_ready_q && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (pop && !head_in_range && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`else
    // Without the stats build nothing observes stalls or dropped writes.
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous RAM model on the memory side.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    localparam int AW    = FB_ADDR_W;
    localparam int DW    = FB_DATA_W;
    localparam int DEPTH = FB_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] drop_cnt;
    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt), .bus(bus));
`else
    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    logic [DW-1:0] ram [DEPTH];
    int ram_oob = 0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (int'(bus.mem_addr) < DEPTH) begin
                if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
                else            bus.mem_rdata     <= ram[bus.mem_addr];
            end else begin
                ram_oob <= ram_oob + 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int we_cnt = 0, en_cnt = 0, busy_cyc = 0, done_cnt = 0, rdy_viol = 0, seq_bad = 0;
    int clr_exp = 0;
    int acc, w0, en0, b0, d0, nbad;
    logic in_clear = 1'b0;
    logic done_seen, found, r;
    logic [DW-1:0] clr_col_exp = '0;
    logic          pv [3];
    logic [DW-1:0] pd [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check the read pipeline model, tally monitors, then drive the next read.
    task automatic tick(input logic req, input int addr, input logic [DW-1:0] expd);
        @(negedge clk);
        chk("rd_valid", 32'(bus.rd_valid), 32'(pv[2]));
        if (pv[2]) chk("rd_data", 32'(bus.rd_data), 32'(pd[2]));
        if (bus.mem_en) en_cnt++;
        if (bus.mem_en && bus.mem_we) begin
            we_cnt++;
            if (in_clear) begin
                if (int'(bus.mem_addr) != clr_exp || bus.mem_wdata != clr_col_exp) seq_bad++;
                clr_exp++;
            end
        end
        if (bus.clear_busy) busy_cyc++;
        if (bus.clear_done) done_cnt++;
        if (bus.clear_busy && bus.wr_ready) rdy_viol++;
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = req;   pd[0] = expd;
        bus.rd_req  = req;
        bus.rd_addr = AW'(addr);
    endtask

    initial begin
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clear_start = 1'b0; bus.clear_color = '0;
        for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i);

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_wr_ready",   32'(bus.wr_ready), 32'd1);
        chk("rst_rd_valid",   32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data",    32'(bus.rd_data), 32'd0);
        chk("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
        chk("rst_clear_done", 32'(bus.clear_done), 32'd0);
        chk("rst_mem_en",     32'(bus.mem_en), 32'd0);
        chk("rst_mem_we",     32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr",   32'(bus.mem_addr), 32'd0);
        rst = 1'b0;

        // back-to-back reads 0..9, data == address
        w0 = we_cnt;
        for (int i = 0; i < 14; i++) tick(i < 10, i, DW'(i));
        chk("rd_no_we", 32'(we_cnt - w0), 32'd0);
        chk("rd_wr_ready", 32'(bus.wr_ready), 32'd1);

        // writer under continuous reads: two accepts, nothing written until reads stop
        w0 = we_cnt; acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 20, DW'(20));
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = 12'hABC;
            if (bus.wr_ready) acc++;
        end
        tick(1'b1, 20, DW'(20));
        bus.wr_valid = 1'b0;
        chk("ctn_ready_low", 32'(bus.wr_ready), 32'd0);
        chk("ctn_accepts", 32'(acc), 32'd2);
        chk("ctn_no_we", 32'(we_cnt - w0), 32'd0);
        repeat (5) tick(1'b0, 0, '0);
        chk("ctn_we", 32'(we_cnt - w0), 32'd2);
        chk("ctn_ram5", 32'(ram[5]), 32'hABC);
        chk("ctn_ready_back", 32'(bus.wr_ready), 32'd1);
`ifdef VGA_FB_ARB_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd4);
`endif

        // out-of-range writes are dropped without a RAM write
        w0 = we_cnt;
        tick(1'b0, 0, '0);
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(DEPTH); bus.wr_data = 12'h123;
        chk("oor_ready0", 32'(bus.wr_ready), 32'd1);
        tick(1'b0, 0, '0);
        bus.wr_addr = AW'(17'h1FFFF); bus.wr_data = 12'h456;
        chk("oor_ready1", 32'(bus.wr_ready), 32'd1);
        tick(1'b0, 0, '0);
        bus.wr_valid = 1'b0;
        repeat (4) tick(1'b0, 0, '0);
        chk("oor_wr_no_we", 32'(we_cnt - w0), 32'd0);
        chk("oor_drained", 32'(bus.wr_ready), 32'd1);
`ifdef VGA_FB_ARB_STATS_EN
        chk("drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // out-of-range read: valid at +3 with zero data, no RAM access
        en0 = en_cnt;
        tick(1'b1, DEPTH, '0);
        repeat (4) tick(1'b0, 0, '0);
        chk("oor_rd_no_en", 32'(en_cnt - en0), 32'd0);

        // full clear, reads every other cycle for the first 2000 cycles
        tick(1'b0, 0, '0);
        bus.clear_start = 1'b1; bus.clear_color = 12'hF00;
        in_clear = 1'b1; clr_exp = 0; clr_col_exp = 12'hF00;
        b0 = busy_cyc; d0 = done_cnt; w0 = we_cnt; rdy_viol = 0; seq_bad = 0;
        done_seen = 1'b0;
        for (int i = 1; i <= 80000 && !done_seen; i++) begin
            r = (i <= 2000) && (i % 2 == 0);
            tick(r, 70000 + i, DW'(70000 + i));
            bus.clear_start = (i == 3000);
            bus.clear_color = (i == 3000) ? 12'h0F0 : 12'hF00;
            if (done_cnt != d0) done_seen = 1'b1;
        end
        bus.clear_start = 1'b0;
        repeat (3) tick(1'b0, 0, '0);
        in_clear = 1'b0;
        chk("clr_done_seen", 32'(done_seen), 32'd1);
        chk("clr_busy_cycles", 32'(busy_cyc - b0), 32'd77800);
        chk("clr_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("clr_writes", 32'(we_cnt - w0), 32'd76800);
        chk("clr_addr_seq", 32'(seq_bad), 32'd0);
        chk("clr_last_addr", 32'(clr_exp), 32'd76800);
        chk("clr_wr_ready_low", 32'(rdy_viol), 32'd0);
        chk("clr_busy_after", 32'(bus.clear_busy), 32'd0);
        chk("clr_ready_after", 32'(bus.wr_ready), 32'd1);
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] != 12'hF00) nbad++;
        chk("clr_ram_fill", 32'(nbad), 32'd0);
        chk("clr_ram_last", 32'(ram[DEPTH-1]), 32'hF00);

        // reset while the clear engine is at address 1000
        tick(1'b0, 0, '0);
        bus.clear_start = 1'b1; bus.clear_color = 12'h00F;
        in_clear = 1'b1; clr_exp = 0; clr_col_exp = 12'h00F; seq_bad = 0;
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            tick(1'b0, 0, '0);
            bus.clear_start = 1'b0;
            if (bus.mem_en && bus.mem_we && int'(bus.mem_addr) == 1000) found = 1'b1;
        end
        chk("rst_reach_1000", 32'(found), 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        tick(1'b0, 0, '0);
        in_clear = 1'b0;
        chk("mid_rst_busy", 32'(bus.clear_busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
        chk("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("mid_rst_done", 32'(bus.clear_done), 32'd0);
        rst = 1'b0;
        repeat (5) tick(1'b0, 0, '0);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_idle", 32'(bus.clear_busy), 32'd0);
        chk("mid_rst_seq", 32'(seq_bad), 32'd0);
        chk("mid_rst_ram1000", 32'(ram[1000]), 32'h00F);
        chk("mid_rst_ram1001", 32'(ram[1001]), 32'hF00);
        chk("ram_oob", 32'(ram_oob), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
